sqrt_iter_q824: RTL and testbench

Iterative unsigned fixed-point square root for the ray marcher datapath: takes a Q8.24 operand, returns its Q8.24 square root, truncated toward zero. It is the forward-direction companion to the inverse-square-root unit and is used where a true distance or length is needed, e.g. |p| for the sphere SDF and step length. It uses a valid/ready handshake on both sides and a radix-2 digit-by-digit datapath that produces one result bit per cycle.

---
 rtl/sqrt_iter_q824_pkg.sv | 21 ++
 rtl/sqrt_iter_q824_step.sv | 25 ++
 rtl/sqrt_iter_q824.sv | 116 +++++++++++
 tb/tb_sqrt_iter_q824.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sqrt_iter_q824_pkg.sv
// Shared widths and Q8.24 constants for the iterative square-root unit.
package sqrt_iter_q824_pkg;

    localparam int unsigned WIDTH     = 32;
    localparam int unsigned FRAC_BITS = 24;
    localparam int unsigned RAD_W     = WIDTH + FRAC_BITS;
    localparam int unsigned ITER      = RAD_W / 2;
    localparam int unsigned REM_W     = ITER + 2;
    localparam int unsigned CNT_W     = 5;

    localparam logic [WIDTH-1:0] FP_ONE  = 32'h0100_0000;
    localparam logic [WIDTH-1:0] FP_TWO  = 32'h0200_0000;
    localparam logic [WIDTH-1:0] FP_HALF = 32'h0080_0000;

    // Result payload as seen by the consumer.
    typedef struct packed {
        logic [WIDTH-1:0] sqrt;
        logic             exact;
    } sqrt_result_t;

endpackage

// File: rtl/sqrt_iter_q824_step.sv
// One radix-2 digit-by-digit square-root iteration (purely combinational).
module sqrt_iter_q824_step
    import sqrt_iter_q824_pkg::*;
(
    input  logic [REM_W-1:0] rem,
    input  logic [ITER-1:0]  root,
    input  logic [1:0]       bits,
    output logic [REM_W-1:0] rem_next,
    output logic [ITER-1:0]  root_next
);

    logic [REM_W+1:0] rem_sh;
    logic [REM_W+1:0] trial;
    logic             ge;

    // Compare at full shifted width; the remainder bound keeps the result in REM_W bits.
    always_comb begin
        rem_sh    = {rem, bits};
        trial     = {2'b00, root, 2'b01};
        ge        = (rem_sh >= trial);
        rem_next  = REM_W'(ge ? (rem_sh - trial) : rem_sh);
        root_next = {root[ITER-2:0], ge};
    end

endmodule

// File: rtl/sqrt_iter_q824.sv
// Iterative Q8.24 square root with valid/ready on both sides, one root bit per cycle.
module sqrt_iter_q824
    import sqrt_iter_q824_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_x,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sqrt,
    output logic             out_exact
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITER - 1);

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic             load;
    logic             step_en;
    logic             finish;

    logic [RAD_W-1:0] rad_q;
    logic [REM_W-1:0] rem_q;
    logic [ITER-1:0]  root_q;
    logic [CNT_W-1:0] cnt_q;
    logic [REM_W-1:0] rem_n;
    logic [ITER-1:0]  root_n;

    sqrt_iter_q824_step u_step (
        .rem       (rem_q),
        .root      (root_q),
        .bits      (rad_q[RAD_W-1:RAD_W-2]),
        .rem_next  (rem_n),
        .root_next (root_n)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step_en = 1'b0;
        finish  = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = BUSY;
                    load    = 1'b1;
                end
            end
            BUSY: begin
                step_en = 1'b1;
                if (cnt_q == LAST_CNT) begin
                    state_d = DONE;
                    finish  = 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Radicand shifts out two MSBs per iteration into the step logic.
    always_ff @(posedge clk) begin
        if (rst) begin
            rad_q  <= '0;
            rem_q  <= '0;
            root_q <= '0;
            cnt_q  <= '0;
        end else if (load) begin
            rad_q  <= {in_x, FRAC_BITS'(0)};
            rem_q  <= '0;
            root_q <= '0;
            cnt_q  <= '0;
        end else if (step_en) begin
            rad_q  <= {rad_q[RAD_W-3:0], 2'b00};
            rem_q  <= rem_n;
            root_q <= root_n;
            cnt_q  <= cnt_q + CNT_W'(1);
        end
    end

    // Result is captured once on the final iteration and held through backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_sqrt  <= '0;
            out_exact <= 1'b0;
        end else begin
            in_ready  <= (state_d == IDLE);
            out_valid <= (state_d == DONE);
            if (finish) begin
                out_sqrt  <= {{(WIDTH - ITER){1'b0}}, root_n};
                out_exact <= (rem_n == '0);
            end
        end
    end

endmodule

// File: tb/tb_sqrt_iter_q824.sv
// Self-checking bench for sqrt_iter_q824: vector table, scoreboard, corner sequences, random sweep.
module tb_sqrt_iter_q824;
    import sqrt_iter_q824_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_x;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_sqrt;
    logic        out_exact;

    always #5 clk = ~clk;

    sqrt_iter_q824 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sqrt  (out_sqrt),
        .out_exact (out_exact)
    );

    typedef struct {
        logic [31:0] sqrt;
        logic        exact;
    } exp_t;

    typedef struct {
        logic [31:0] x;
        logic [31:0] sqrt;
        logic        exact;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    exp_t        sb_q[$];
    exp_t        e;
    logic [31:0] drv_exp_sqrt = '0;
    logic        drv_exp_exact = 1'b0;
    bit          b2b_mode = 1'b0;

    int unsigned acc_cyc = 0;
    bit          have_acc = 1'b0;
    bit          acc_was_b2b = 1'b0;
    logic        prev_ov = 1'b0;
    logic        prev_or = 1'b0;
    logic [31:0] prev_sqrt = '0;
    logic        prev_exact = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    function automatic exp_t model(input logic [31:0] x);
        longint unsigned r, lo, hi, mid;
        exp_t res;
        r  = {8'd0, x, 24'd0};
        lo = 0;
        hi = 64'd1 << 28;
        while (hi - lo > 1) begin
            mid = (lo + hi) >> 1;
            if (mid * mid <= r) lo = mid;
            else hi = mid;
        end
        res.sqrt  = 32'(lo);
        res.exact = (lo * lo == r);
        return res;
    endfunction

    // Monitor: inputs and outputs are stable at the falling edge; a handshake seen here completes at the next rising edge.
    always @(negedge clk) begin
        if (rst) begin
            sb_q.delete();
            have_acc = 1'b0;
        end else begin
            if (prev_ov && !prev_or) begin
                check("hold_valid", 64'(out_valid), 64'(1));
                check("hold_sqrt", 64'(out_sqrt), 64'(prev_sqrt));
                check("hold_exact", 64'(out_exact), 64'(prev_exact));
            end
            if (out_valid && !prev_ov && have_acc)
                check("latency", 64'(cyc - acc_cyc), 64'(29));
            if (in_valid && in_ready) begin
                if (b2b_mode && acc_was_b2b && have_acc)
                    check("b2b_interval", 64'(cyc - acc_cyc), 64'(30));
                acc_cyc     = cyc;
                have_acc    = 1'b1;
                acc_was_b2b = b2b_mode;
                sb_q.push_back('{sqrt: drv_exp_sqrt, exact: drv_exp_exact});
            end
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_out actual=0x%0h required=no_result", out_sqrt);
                end else begin
                    e = sb_q.pop_front();
                    check("sqrt", 64'(out_sqrt), 64'(e.sqrt));
                    check("exact", 64'(out_exact), 64'(e.exact));
                end
            end
        end
        prev_ov    = out_valid;
        prev_or    = out_ready;
        prev_sqrt  = out_sqrt;
        prev_exact = out_exact;
    end

    // Drive one operand; entered and left just after a rising edge.
    task automatic send(input logic [31:0] x, input logic [31:0] es, input logic ee, input bit keep_valid);
        int n = 0;
        in_valid      = 1'b1;
        in_x          = x;
        drv_exp_sqrt  = es;
        drv_exp_exact = ee;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 200) begin
                check("accept_timeout", 64'(in_ready), 64'(1));
                break;
            end
        end
        @(posedge clk);
        #1;
        if (!keep_valid) in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain_timeout", 64'(sb_q.size()), 64'(0));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        vec_t vecs[6];
        exp_t m;
        bit   saw;
        int   n;

        vecs[0] = '{x: 32'h0100_0000, sqrt: 32'h0100_0000, exact: 1'b1};
        vecs[1] = '{x: 32'h0400_0000, sqrt: 32'h0200_0000, exact: 1'b1};
        vecs[2] = '{x: 32'h0040_0000, sqrt: 32'h0080_0000, exact: 1'b1};
        vecs[3] = '{x: 32'h0000_0000, sqrt: 32'h0000_0000, exact: 1'b1};
        vecs[4] = '{x: 32'h0200_0000, sqrt: 32'h016A_09E6, exact: 1'b0};
        vecs[5] = '{x: 32'hFFFF_FFFF, sqrt: 32'h0FFF_FFFF, exact: 1'b0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_x      = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'(1));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_sqrt", 64'(out_sqrt), 64'(0));
        check("rst_out_exact", 64'(out_exact), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            send(vecs[i].x, vecs[i].sqrt, vecs[i].exact, 1'b0);
            wait_drain();
        end

        // Backpressure: result must hold, input side stays closed.
        out_ready = 1'b0;
        send(32'h0100_0000, 32'h0100_0000, 1'b1, 1'b0);
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("bp_valid_seen", 64'(out_valid), 64'(1));
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            in_valid = (i == 5);
            in_x     = 32'h0900_0000;
            @(negedge clk);
            check("bp_in_ready", 64'(in_ready), 64'(0));
            check("bp_out_valid", 64'(out_valid), 64'(1));
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_no_turnaround", 64'(in_ready), 64'(0));
        @(posedge clk);
        #1;
        @(negedge clk);
        check("bp_ready_after", 64'(in_ready), 64'(1));
        check("bp_valid_after", 64'(out_valid), 64'(0));
        check("bp_sb_empty", 64'(sb_q.size()), 64'(0));
        @(posedge clk);
        #1;

        // Reset in BUSY cycle 12, with in_valid also high: result discarded.
        send(32'h0400_0000, 32'h0200_0000, 1'b1, 1'b0);
        repeat (11) @(posedge clk);
        #1;
        rst      = 1'b1;
        in_valid = 1'b1;
        in_x     = 32'h0100_0000;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("rstbusy_in_ready", 64'(in_ready), 64'(1));
        check("rstbusy_out_valid", 64'(out_valid), 64'(0));
        saw = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) saw = 1'b1;
        end
        check("rstbusy_no_valid", 64'(saw), 64'(0));
        @(posedge clk);
        #1;

        // Reset and in_valid together in IDLE: nothing accepted.
        rst      = 1'b1;
        in_valid = 1'b1;
        in_x     = 32'h0400_0000;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        saw = 1'b0;
        repeat (35) begin
            @(negedge clk);
            if (out_valid) saw = 1'b1;
        end
        check("rstidle_no_valid", 64'(saw), 64'(0));
        check("rstidle_in_ready", 64'(in_ready), 64'(1));
        @(posedge clk);
        #1;

        send(32'h0900_0000, 32'h0300_0000, 1'b1, 1'b0);
        wait_drain();

        // Back-to-back random sweep with out_ready tied high.
        b2b_mode = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            logic [31:0] x;
            case (i)
                0:       x = 32'h0000_0001;
                1:       x = 32'hFFFF_FFFF;
                2:       x = 32'h0900_0000;
                3:       x = 32'h8000_0000;
                default: x = $urandom;
            endcase
            m = model(x);
            send(x, m.sqrt, m.exact, 1'b1);
        end
        in_valid = 1'b0;
        wait_drain();
        b2b_mode = 1'b0;

        repeat (5) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
